// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan-code bytes and serialises
// each one as an 11-bit frame (start, 8 data LSB first, odd parity, stop).
module ps2_kbd_tx #(
    parameter int CLK_DIV = 50,
    parameter int GAP     = 100,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic [10:0]   shift;
    logic [7:0]    cur_byte, load_byte;
    logic          hold_vld;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic          push, pop, start, abort, div_last, shift_en;

    assign push      = in_valid & in_ready;
    assign load_byte = hold_vld ? cur_byte : mem[rd_ptr];
    assign start     = (state == ST_IDLE) && (hold_vld || (count != '0)) &&
                       !inhibit && (gap_cnt == '0);
    // A retained (aborted) byte is resent from the holding register, not the FIFO.
    assign pop       = start && !hold_vld;
    assign abort     = ((state == ST_HIGH) || (state == ST_LOW)) && inhibit &&
                       (bit_cnt < 4'd10);
    assign div_last  = (div_cnt == DW'(CLK_DIV - 1));
    assign shift_en  = (state == ST_LOW) && !abort && div_last && (bit_cnt != 4'd10);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            in_ready <= (count_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            shift    <= {1'b1, ~^load_byte, load_byte, 1'b0};
            cur_byte <= load_byte;
        end else if (shift_en) begin
            shift <= {1'b1, shift[10:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            hold_vld   <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state    <= ST_GAP;
                ps2_clk  <= 1'b1;
                ps2_data <= 1'b1;
                busy     <= 1'b0;
                hold_vld <= 1'b1;
                div_cnt  <= '0;
                gap_cnt  <= GW'(GAP);
            end else begin
                case (state)
                    ST_IDLE: begin
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                        if (start) begin
                            state    <= ST_HIGH;
                            ps2_data <= 1'b0;
                            busy     <= 1'b1;
                            hold_vld <= 1'b0;
                            bit_cnt  <= '0;
                            div_cnt  <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (div_last) begin
                            state   <= ST_LOW;
                            ps2_clk <= 1'b0;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (div_last) begin
                            div_cnt <= '0;
                            ps2_clk <= 1'b1;
                            if (bit_cnt != 4'd10) begin
                                state    <= ST_HIGH;
                                bit_cnt  <= bit_cnt + 1'b1;
                                ps2_data <= shift[1];
                            end else begin
                                state      <= ST_GAP;
                                ps2_data   <= 1'b1;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                gap_cnt    <= GW'(GAP);
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                        // Host holding the line restarts the quiet period.
                        if (inhibit) begin
                            gap_cnt <= GW'(GAP);
                        end else if (gap_cnt <= GW'(1)) begin
                            gap_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a host-side receiver model decodes the PS/2
// lines and each scenario task checks its own results.
module tb_ps2_kbd_tx;

    localparam int CDIV  = 4;
    localparam int GAPC  = 8;
    localparam int DEP   = 4;
    localparam int TMO   = 5000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       inhibit;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kbd_tx #(.CLK_DIV(CDIV), .GAP(GAPC), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .inhibit    (inhibit),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Host receiver model, sampled on the falling system-clock edge.
    logic [7:0]  rx_q[$];
    logic        par_q[$];
    logic [10:0] sh = '0;
    logic [10:0] last_bits = '0;
    logic        prev_clk = 1'b1;
    logic        prev_busy = 1'b0;
    logic        have_prev = 1'b0;
    int nbits = 0, idle_cnt = 0, rx_bad = 0, aborts = 0;
    int fd_cnt = 0, busy_cycles = 0, idle_bad = 0, low_run = 0, min_gap = 1000000;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits    = 0;
            idle_cnt = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk) begin
                sh[nbits] = ps2_data;
                nbits++;
                idle_cnt = 0;
                if (nbits == 11) begin
                    last_bits = sh;
                    if (sh[0] !== 1'b0 || sh[10] !== 1'b1 || (^sh[9:1]) !== 1'b1)
                        rx_bad++;
                    rx_q.push_back(sh[8:1]);
                    par_q.push_back(sh[9]);
                    nbits = 0;
                end
            end else begin
                idle_cnt++;
                if (nbits != 0 && idle_cnt > 3*CDIV) begin
                    nbits = 0;
                    aborts++;
                end
            end
            prev_clk = ps2_clk;
            if (frame_done) fd_cnt++;
            if (busy) busy_cycles++;
            if (!busy && (ps2_clk !== 1'b1 || ps2_data !== 1'b1)) idle_bad++;
            if (busy && !prev_busy && have_prev && low_run < min_gap) min_gap = low_run;
            if (!busy && prev_busy) have_prev = 1'b1;
            if (!busy) low_run++; else low_run = 0;
            prev_busy = busy;
        end
    end

    task automatic push(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL push_ready_timeout: in_ready=%0b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < TMO) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rx_q.size() < n) begin
            n_fail++;
            $display("FAIL rx_timeout: frames received %0d, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inhibit = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (ps2_clk !== 1'b1)    begin n_fail++; $display("FAIL rst_ps2_clk: got %b, required 1", ps2_clk); end
        if (ps2_data !== 1'b1)   begin n_fail++; $display("FAIL rst_ps2_data: got %b, required 1", ps2_data); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int r0 = rx_q.size();
        int f0 = fd_cnt;
        int b0 = busy_cycles;
        push(8'h1C);
        wait_rx(r0 + 1);
        repeat (3*CDIV + GAPC) @(negedge clk);
        n_checks += 5;
        if (last_bits !== 11'b100_0011_1000) begin n_fail++; $display("FAIL frame_1c_bits: got %b, required 10000111000", last_bits); end
        if (rx_q[r0] !== 8'h1C)              begin n_fail++; $display("FAIL frame_1c_byte: got %h, required 1c", rx_q[r0]); end
        if (fd_cnt - f0 != 1)                begin n_fail++; $display("FAIL frame_1c_done: pulses %0d, required 1", fd_cnt - f0); end
        if (busy_cycles - b0 != 22*CDIV)     begin n_fail++; $display("FAIL frame_1c_len: busy cycles %0d, required %0d", busy_cycles - b0, 22*CDIV); end
        if (rx_bad != 0)                     begin n_fail++; $display("FAIL frame_1c_format: bad frames %0d, required 0", rx_bad); end
    endtask

    task automatic test_back_to_back();
        int r0 = rx_q.size();
        push(8'h00);
        push(8'hFF);
        wait_rx(r0 + 2);
        n_checks += 5;
        if (rx_q[r0] !== 8'h00)     begin n_fail++; $display("FAIL b2b_byte0: got %h, required 00", rx_q[r0]); end
        if (rx_q[r0+1] !== 8'hFF)   begin n_fail++; $display("FAIL b2b_byte1: got %h, required ff", rx_q[r0+1]); end
        if (par_q[r0] !== 1'b1)     begin n_fail++; $display("FAIL b2b_par0: got %b, required 1", par_q[r0]); end
        if (par_q[r0+1] !== 1'b1)   begin n_fail++; $display("FAIL b2b_par1: got %b, required 1", par_q[r0+1]); end
        if (min_gap < GAPC)         begin n_fail++; $display("FAIL b2b_gap: min idle gap %0d, required >= %0d", min_gap, GAPC); end
        repeat (3*CDIV + GAPC) @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int r0 = rx_q.size();
        int t = 0;
        push(exp[0]);
        while (!busy && t < 100) begin @(negedge clk); t++; end
        for (int i = 1; i <= DEP; i++) push(exp[i]);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_ready: got %b, required 0", in_ready); end
        push(exp[5]);
        wait_rx(r0 + 6);
        repeat (20*CDIV) @(negedge clk);
        n_checks += 2;
        if (rx_q.size() != r0 + 6) begin n_fail++; $display("FAIL fifo_count: frames %0d, required %0d", rx_q.size() - r0, 6); end
        if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL fifo_drained_ready: got %b, required 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rx_q[r0+i] !== exp[i]) begin n_fail++; $display("FAIL fifo_order%0d: got %h, required %h", i, rx_q[r0+i], exp[i]); end
        end
    endtask

    task automatic test_inhibit();
        int r0 = rx_q.size();
        int f0 = fd_cnt;
        int a0 = aborts;
        int t = 0;
        push(8'hA5);
        push(8'h3C);
        while (nbits < 5 && t < TMO) begin @(negedge clk); t++; end
        inhibit = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL inh_busy: got %b, required 0", busy); end
        if (ps2_clk !== 1'b1)  begin n_fail++; $display("FAIL inh_clk: got %b, required 1", ps2_clk); end
        if (ps2_data !== 1'b1) begin n_fail++; $display("FAIL inh_data: got %b, required 1", ps2_data); end
        repeat (199) @(negedge clk);
        n_checks += 2;
        if (fd_cnt != f0)         begin n_fail++; $display("FAIL inh_no_done: pulses %0d, required 0", fd_cnt - f0); end
        if (rx_q.size() != r0)    begin n_fail++; $display("FAIL inh_no_frame: frames %0d, required 0", rx_q.size() - r0); end
        inhibit = 1'b0;
        wait_rx(r0 + 2);
        repeat (3*CDIV + GAPC) @(negedge clk);
        n_checks += 6;
        if (rx_q[r0] !== 8'hA5)   begin n_fail++; $display("FAIL inh_resend: got %h, required a5", rx_q[r0]); end
        if (rx_q[r0+1] !== 8'h3C) begin n_fail++; $display("FAIL inh_next: got %h, required 3c", rx_q[r0+1]); end
        if (aborts - a0 != 1)     begin n_fail++; $display("FAIL inh_abort: aborted frames %0d, required 1", aborts - a0); end
        if (fd_cnt - f0 != 2)     begin n_fail++; $display("FAIL inh_done: pulses %0d, required 2", fd_cnt - f0); end
        if (idle_bad != 0)        begin n_fail++; $display("FAIL idle_lines: non-high idle cycles %0d, required 0", idle_bad); end
        if (rx_bad != 0)          begin n_fail++; $display("FAIL inh_format: bad frames %0d, required 0", rx_bad); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        int r0, f0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        while (!(nbits >= 3 && ps2_clk == 1'b0) && t < TMO) begin @(negedge clk); t++; end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (ps2_clk !== 1'b1)  begin n_fail++; $display("FAIL arst_clk: got %b, required 1", ps2_clk); end
        if (ps2_data !== 1'b1) begin n_fail++; $display("FAIL arst_data: got %b, required 1", ps2_data); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL arst_busy: got %b, required 0", busy); end
        repeat (2) @(negedge clk);
        r0 = rx_q.size();
        f0 = fd_cnt;
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        n_checks += 3;
        if (rx_q.size() != r0) begin n_fail++; $display("FAIL arst_flush: frames %0d, required 0", rx_q.size() - r0); end
        if (fd_cnt != f0)      begin n_fail++; $display("FAIL arst_done: pulses %0d, required 0", fd_cnt - f0); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_loopback();
        int r0 = rx_q.size();
        push(8'hF0);
        push(8'h1C);
        wait_rx(r0 + 2);
        n_checks += 5;
        if (rx_q[r0] !== 8'hF0)   begin n_fail++; $display("FAIL loop_byte0: got %h, required f0", rx_q[r0]); end
        if (rx_q[r0+1] !== 8'h1C) begin n_fail++; $display("FAIL loop_byte1: got %h, required 1c", rx_q[r0+1]); end
        if (par_q[r0] !== 1'b1)   begin n_fail++; $display("FAIL loop_par0: got %b, required 1", par_q[r0]); end
        if (par_q[r0+1] !== 1'b0) begin n_fail++; $display("FAIL loop_par1: got %b, required 0", par_q[r0+1]); end
        if (rx_bad != 0)          begin n_fail++; $display("FAIL loop_format: bad frames %0d, required 0", rx_bad); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_inhibit();
        test_reset_mid();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
